// File: rtl/multiply_dequant_pkg.sv
// Shared fixed-point helpers for the radio datapath: default Q-format sizes
// and the product-to-result dequantize step.
package multiply_dequant_pkg;

  localparam int unsigned DQ_WIDTH    = 32;
  localparam int unsigned DQ_BITS     = 10;
  // Widest product the helper accepts; callers sign-extend into it.
  localparam int unsigned DQ_PROD_MAX = 128;

  typedef logic signed [DQ_PROD_MAX-1:0] dq_prod_t;

  // Divide by 2^bits rounding toward zero: negative values are biased by
  // 2^bits-1 so the arithmetic shift does not round them down.
  function automatic dq_prod_t dequantize(input dq_prod_t prod, input int unsigned bits);
    dq_prod_t bias;
    dq_prod_t biased;
    bias   = '1;
    bias   = ~(bias << bits);
    biased = prod[DQ_PROD_MAX-1] ? prod + bias : prod;
    return biased >>> bits;
  endfunction

endpackage

// File: rtl/multiply_dequant.sv
// Three-stage signed multiply + fixed-point dequantize between FWFT input
// FIFOs and an output FIFO; all stages advance on one shared enable.
module multiply_dequant
  import multiply_dequant_pkg::*;
#(
  parameter int unsigned WIDTH = DQ_WIDTH,
  parameter int unsigned BITS  = DQ_BITS
) (
  input  logic             clock,
  input  logic             reset,
  output logic             inA_rd_en,
  input  logic             inA_empty,
  input  logic [WIDTH-1:0] inA_dout,
  output logic             inB_rd_en,
  input  logic             inB_empty,
  input  logic [WIDTH-1:0] inB_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [WIDTH-1:0] out_din
);

  localparam int unsigned PW = 2 * WIDTH;

  logic                    en;
  logic                    pop;
  logic                    s1_v, s2_v, s3_v;
  logic signed [WIDTH-1:0] s1_a, s1_b;
  logic signed [PW-1:0]    s2_p;
  logic signed [WIDTH-1:0] s3_d;

  // Bubbles in S3 never stall; only a real result facing a full FIFO does.
  assign en        = !(s3_v && out_full);
  assign pop       = !inA_empty && !inB_empty && en;
  assign inA_rd_en = pop;
  assign inB_rd_en = pop;
  assign out_wr_en = s3_v && !out_full;
  assign out_din   = s3_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s2_p <= '0;
      s3_d <= '0;
    end else if (en) begin
      s1_v <= pop;
      s1_a <= inA_dout;
      s1_b <= inB_dout;
      s2_v <= s1_v;
      s2_p <= PW'(s1_a) * PW'(s1_b);
      s3_v <= s2_v;
      s3_d <= WIDTH'(dequantize(DQ_PROD_MAX'(s2_p), BITS));
    end
  end

endmodule

// File: tb/tb_multiply_dequant.sv
// Scoreboard bench: FWFT FIFO models feed the DUT, expected results are
// queued at push time and checked by a monitor on each output write.
module tb_multiply_dequant;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BITS  = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             inA_rd_en, inB_rd_en, out_wr_en;
  logic             inA_empty = 1'b1, inB_empty = 1'b1;
  logic [WIDTH-1:0] inA_dout = '0, inB_dout = '0;
  logic             out_full = 1'b0;
  logic [WIDTH-1:0] out_din;

  multiply_dequant #(.WIDTH(WIDTH), .BITS(BITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .inA_rd_en(inA_rd_en),
    .inA_empty(inA_empty),
    .inA_dout (inA_dout),
    .inB_rd_en(inB_rd_en),
    .inB_empty(inB_empty),
    .inB_dout (inB_dout),
    .out_wr_en(out_wr_en),
    .out_full (out_full),
    .out_din  (out_din)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int rd_seen = 0;
  int last_pop_cyc = 0;
  int writes = 0;
  int wr_cyc = -10;
  int run = 0;

  logic signed [WIDTH-1:0] qa[$];
  logic signed [WIDTH-1:0] qb[$];
  logic signed [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic refresh();
    inA_empty = (qa.size() == 0);
    inB_empty = (qb.size() == 0);
    inA_dout  = inA_empty ? '0 : qa[0];
    inB_dout  = inB_empty ? '0 : qb[0];
  endtask

  task automatic push(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                      input logic signed [WIDTH-1:0] e);
    qa.push_back(a);
    qb.push_back(b);
    exp_q.push_back(e);
    refresh();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clock);
      if (exp_q.size() == 0) break;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // FWFT FIFO model: pop what the DUT saw requested at this edge.
  always @(posedge clock) begin
    logic pa, pb;
    pa = inA_rd_en;
    pb = inB_rd_en;
    if (pa || pb) begin
      rd_seen++;
      if (pa && pb) begin
        pops++;
        last_pop_cyc = cyc;
      end
    end
    #1;
    if (pa && qa.size() > 0) void'(qa.pop_front());
    if (pb && qb.size() > 0) void'(qb.pop_front());
    refresh();
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (inA_rd_en || inB_rd_en) chk("rd_en_match", inA_rd_en, inB_rd_en);
      if (out_wr_en) begin
        writes++;
        run    = (wr_cyc + 1 == cyc) ? run + 1 : 1;
        wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0d expected none", $signed(out_din));
        end else begin
          chk("result", $signed(out_din), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int p0, w0, r0;

    repeat (2) @(negedge clock);
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_rd_en", inA_rd_en, 0);
    chk("rst_dout", out_din, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_wr_en", out_wr_en, 0);

    // Basic product and latency
    push(1024, 1024, 1024);
    drain(20);
    chk("latency", wr_cyc - last_pop_cyc, 3);

    // Toward-zero truncation and negatives
    @(negedge clock);
    push(-3, 5, 0);
    push(2048, -1536, -3072);
    push(-1, 1, 0);
    push(-100, 1024, -100);
    push(3000, 4000, 11718);
    push(32'sh4000_0000, 4096, 0);
    drain(30);

    // Ten back-to-back pairs
    @(negedge clock);
    for (int i = 0; i < 10; i++) push(i * 1024, 2048, i * 2048);
    w0 = writes;
    drain(40);
    chk("burst_count", writes - w0, 10);
    chk("burst_run", run, 10);

    // Backpressure: full before data arrives; bubbles must not block pops
    @(negedge clock);
    out_full = 1'b1;
    p0 = pops;
    w0 = writes;
    push(100, 1024, 100);
    push(-7, 2048, -14);
    push(5120, 3072, 15360);
    push(-2048, -2048, 4096);
    repeat (6) @(negedge clock);
    chk("stall_pops", pops - p0, 3);
    chk("stall_writes", writes - w0, 0);
    chk("stall_fifo_a", qa.size(), 1);
    out_full = 1'b0;
    drain(30);
    chk("stall_total", writes - w0, 4);

    // Only one FIFO non-empty: no pop at all
    @(negedge clock);
    r0 = rd_seen;
    qa.push_back(7);
    refresh();
    repeat (4) @(negedge clock);
    chk("one_empty_rd", rd_seen - r0, 0);
    chk("one_empty_fifo_a", qa.size(), 1);
    qb.push_back(1024);
    exp_q.push_back(7);
    refresh();
    drain(20);

    // Reset with two operations in flight
    @(negedge clock);
    push(11, 1024, 11);
    push(12, 1024, 12);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", out_wr_en, 0);
    chk("midrst_dout", out_din, 0);
    exp_q.delete();
    w0 = writes;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("post_rst_writes", writes - w0, 0);
    push(9, 1024, 9);
    drain(20);
    chk("post_rst_new", writes - w0, 1);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/multiply_dequant.md
MULTIPLY_DEQUANT -- requirements
Module: multiply_dequant

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter BITS, default 10: fixed-point fraction bits removed after multiplication.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inA_rd_en  output  1  pops operand A from the first-word-fall-through (FWFT) FIFO.
REQ-006 inA_empty  input  1  operand A FIFO empty.
REQ-007 inA_dout  input  WIDTH  operand A, signed, valid while inA_empty is low.
REQ-008 inB_rd_en  output  1  pops operand B from the FWFT FIFO.
REQ-009 inB_empty  input  1  operand B FIFO empty.
REQ-010 inB_dout  input  WIDTH  operand B, signed, valid while inB_empty is low.
REQ-011 out_wr_en  output  1  pushes the result into the output FIFO.
REQ-012 out_full  input  1  output FIFO full.
REQ-013 out_din  output  WIDTH  signed result.

Function
REQ-014 Result SHALL be the signed 2*WIDTH product of A and B, divided by 2^BITS with truncation toward zero, then truncated to the low WIDTH bits (wrap, no saturation).
REQ-015 Truncation toward zero SHALL be implemented by adding 2^BITS-1 to a negative product before an arithmetic right shift by BITS.
REQ-016 The pipeline SHALL have three register stages: S1 latches operands; S2 holds the full product; S3 holds the dequantized result and drives out_din.
REQ-017 Each stage SHALL carry a valid bit; advance enable en = !(S3.valid && out_full).
REQ-018 inA_rd_en and inB_rd_en SHALL both equal (!inA_empty && !inB_empty && en), so they are always identical.
REQ-019 When en is high, every stage SHALL load from its predecessor; S1.valid SHALL load the pop condition (a bubble on no pop).
REQ-020 When en is low, every stage register and valid bit SHALL hold.
REQ-021 out_wr_en SHALL equal S3.valid && !out_full; out_din SHALL equal the S3 data whenever S3.valid is high.
REQ-022 Latency: a pop at edge N SHALL produce out_wr_en during the cycle after edge N+2, absent backpressure.
REQ-023 Throughput SHALL be one result per cycle while inputs are non-empty and out_full is low.
REQ-024 No result SHALL ever be dropped or duplicated; results SHALL leave in pop order.
REQ-025 out_full asserting while S3.valid is high SHALL freeze the pipeline the same cycle; the held result SHALL be written in the first cycle out_full is low.
REQ-026 One input empty and the other non-empty SHALL produce no pop on either FIFO.
REQ-027 A stall with only bubbles in S3 SHALL NOT block pops (en stays high).

Reset
REQ-028 Reset SHALL clear all valid bits and data registers to zero asynchronously.
REQ-029 During and after reset, out_wr_en, inA_rd_en and inB_rd_en SHALL be 0 until a valid pop condition occurs; out_din SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight results; no write SHALL follow reset deassertion for pre-reset operands.

Structure
REQ-031 WIDTH and BITS defaults and a dequantize function (product -> WIDTH result) SHALL live in the shared fixed-point package used by the radio datapath.
REQ-032 The block SHALL be one module with no sub-module; the three stages SHALL share one enable.

Verification
REQ-033 A=1024, B=1024, no backpressure -> out_din=1024, out_wr_en exactly 3 cycles after the pop edge.
REQ-034 A=-3, B=5 -> out_din=0 (toward zero, not -1); A=2048, B=-1536 -> out_din=-3072.
REQ-035 Ten back-to-back pairs with A=i*1024, B=2048 (i=0..9) -> ten consecutive writes, values i*2048 in order.
REQ-036 Four ops in flight, then out_full held high for 5 cycles -> no write while full; all four results are written in order afterwards with no loss.
REQ-037 inA non-empty, inB empty for 4 cycles -> no rd_en asserted, FIFO A contents unchanged.
REQ-038 Reset pulsed with 2 ops in flight -> outputs 0 immediately; no writes after release until new pops.
